// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one request to an external combinational 32-bit ALU.
// Single-word ops take one ALU pass. ADD64/SUB64 take two chained passes,
// low word first. Results and flags come back over a registered response handshake.
//
// Build option: define ALU_SEQ_WIDE_EN to enable ADD64/SUB64 and the HI state.
// When it is undefined, ops 9/10 are illegal and rsp_result[63:32] stays 0.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for a request, req_ready=1
// LO    | first (or only) ALU pass is on the ALU inputs
// HI    | upper-word pass of ADD64/SUB64
// RESP  | response held until rsp_ready
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_cntl,
  output logic        alu_carry_in,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry_out,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_err
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_BNE   = 4'd8;
`ifdef ALU_SEQ_WIDE_EN
  localparam logic [3:0] OP_ADD64 = 4'd9;
  localparam logic [3:0] OP_SUB64 = 4'd10;
`endif

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_BNE  = 4'b0111;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_SLT  = 4'b1101;
  localparam logic [3:0] C_SLTU = 4'b1110;

`ifdef ALU_SEQ_WIDE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_RESP = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic        arith_q, arith_d;      // ADD/SUB: ALU carry/overflow are meaningful
  logic        illegal_q, illegal_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_cntl_q, alu_cntl_d;
  logic        alu_cin_q, alu_cin_d;
  logic [63:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef ALU_SEQ_WIDE_EN
  logic        wide_q, wide_d;
  logic [31:0] a_hi_q, a_hi_d;
  logic [31:0] b_hi_q, b_hi_d;        // already inverted for SUB64
  logic [31:0] lo_result_q, lo_result_d;
  logic        lo_zero_q, lo_zero_d;
  logic        dec_wide;
`else
  logic        unused_hi;
  assign unused_hi = ^{req_a[63:32], req_b[63:32]};
`endif

  logic [3:0]  dec_cntl;
  logic        dec_arith;
  logic        dec_illegal;
  logic        dec_invert_b;

  // Decode the request opcode into ALU control and op class
  always_comb begin
    dec_cntl     = C_AND;
    dec_arith    = 1'b0;
    dec_illegal  = 1'b0;
    dec_invert_b = 1'b0;
`ifdef ALU_SEQ_WIDE_EN
    dec_wide     = 1'b0;
`endif
    case (req_op)
      OP_ADD:  begin dec_cntl = C_ADD; dec_arith = 1'b1; end
      OP_SUB:  begin dec_cntl = C_SUB; dec_arith = 1'b1; end
      OP_AND:  dec_cntl = C_AND;
      OP_OR:   dec_cntl = C_OR;
      OP_XOR:  dec_cntl = C_XOR;
      OP_NOR:  dec_cntl = C_NOR;
      OP_SLT:  dec_cntl = C_SLT;
      OP_SLTU: dec_cntl = C_SLTU;
      OP_BNE:  dec_cntl = C_BNE;
`ifdef ALU_SEQ_WIDE_EN
      // The ALU's subtract ignores CarryIn, so SUB64 is add-with-inverted-B.
      OP_ADD64: begin dec_cntl = C_ADD; dec_wide = 1'b1; end
      OP_SUB64: begin dec_cntl = C_ADD; dec_wide = 1'b1; dec_invert_b = 1'b1; end
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state, ALU drive and response capture
  always_comb begin
    state_d      = state_q;
    arith_d      = arith_q;
    illegal_d    = illegal_q;
    alu_a_d      = 32'h0;
    alu_b_d      = 32'h0;
    alu_cntl_d   = 4'b0000;
    alu_cin_d    = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
`ifdef ALU_SEQ_WIDE_EN
    wide_d       = wide_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    lo_result_d  = lo_result_q;
    lo_zero_d    = lo_zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d   = S_LO;
          arith_d   = dec_arith;
          illegal_d = dec_illegal;
          if (!dec_illegal) begin
            alu_a_d    = req_a[31:0];
            alu_b_d    = dec_invert_b ? ~req_b[31:0] : req_b[31:0];
            alu_cntl_d = dec_cntl;
            alu_cin_d  = dec_invert_b;
          end
`ifdef ALU_SEQ_WIDE_EN
          wide_d = dec_wide;
          a_hi_d = req_a[63:32];
          b_hi_d = dec_invert_b ? ~req_b[63:32] : req_b[63:32];
`endif
        end
      end
      S_LO: begin
`ifdef ALU_SEQ_WIDE_EN
        if (wide_q) begin
          state_d     = S_HI;
          alu_a_d     = a_hi_q;
          alu_b_d     = b_hi_q;
          alu_cntl_d  = C_ADD;
          alu_cin_d   = alu_carry_out;
          lo_result_d = alu_out;
          lo_zero_d   = alu_zero;
        end else
`endif
        begin
          state_d = S_RESP;
          if (illegal_q) begin
            rsp_result_d = 64'h0;
            rsp_zero_d   = 1'b1;
            rsp_carry_d  = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_err_d    = 1'b1;
          end else begin
            rsp_result_d = {32'h0, alu_out};
            rsp_zero_d   = alu_zero;
            // Carry/overflow float for logic ops; never let that reach the response.
            rsp_carry_d  = arith_q ? alu_carry_out : 1'b0;
            rsp_ovf_d    = arith_q ? alu_overflow  : 1'b0;
            rsp_err_d    = 1'b0;
          end
        end
      end
`ifdef ALU_SEQ_WIDE_EN
      S_HI: begin
        state_d      = S_RESP;
        rsp_result_d = {alu_out, lo_result_q};
        rsp_zero_d   = lo_zero_q & alu_zero;
        rsp_carry_d  = alu_carry_out;
        rsp_ovf_d    = alu_overflow;
        rsp_err_d    = 1'b0;
      end
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, ALU drive and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      arith_q      <= 1'b0;
      illegal_q    <= 1'b0;
      alu_a_q      <= 32'h0;
      alu_b_q      <= 32'h0;
      alu_cntl_q   <= 4'b0000;
      alu_cin_q    <= 1'b0;
      rsp_result_q <= 64'h0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_WIDE_EN
      wide_q       <= 1'b0;
      a_hi_q       <= 32'h0;
      b_hi_q       <= 32'h0;
      lo_result_q  <= 32'h0;
      lo_zero_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      arith_q      <= arith_d;
      illegal_q    <= illegal_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cntl_q   <= alu_cntl_d;
      alu_cin_q    <= alu_cin_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_SEQ_WIDE_EN
      wide_q       <= wide_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      lo_result_q  <= lo_result_d;
      lo_zero_q    <= lo_zero_d;
`endif
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cntl     = alu_cntl_q;
  assign alu_carry_in = alu_cin_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural model of the ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [63:0] req_a = 64'h0;
  logic [63:0] req_b = 64'h0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_cntl;
  logic        alu_carry_in;
  logic [31:0] alu_out;
  logic        alu_zero;
  wire         alu_carry_out;
  wire         alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_result;
  logic        rsp_zero, rsp_carry, rsp_overflow, rsp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntl(alu_cntl), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
  );

  // Combinational MIPS ALU; carry/overflow float except for add/sub
  logic m_c, m_v, m_drv;
  always_comb begin
    logic [32:0] s;
    s = 33'h0; alu_out = 32'h0; m_c = 1'b0; m_v = 1'b0; m_drv = 1'b0;
    case (alu_cntl)
      4'b0010: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {32'h0, alu_carry_in};
        alu_out = s[31:0]; m_c = s[32]; m_drv = 1'b1;
        m_v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'b0110: begin
        alu_out = alu_a - alu_b; m_c = (alu_a >= alu_b); m_drv = 1'b1;
        m_v = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0011: alu_out = alu_a ^ alu_b;
      4'b1100: alu_out = ~(alu_a | alu_b);
      4'b1101: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'h1 : 32'h0;
      4'b1110: alu_out = (alu_a < alu_b) ? 32'h1 : 32'h0;
      4'b0111: alu_out = (alu_a == alu_b) ? 32'h11111111 : 32'h0;
      default: alu_out = 32'h0;
    endcase
    alu_zero = (alu_out == 32'h0);
  end
  assign alu_carry_out = m_drv ? m_c : 1'bz;
  assign alu_overflow  = m_drv ? m_v : 1'bz;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Present a request from IDLE, then wait (bounded) for rsp_valid.
  // lat = edges from presenting the request until rsp_valid is seen.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output int lat);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    tick(); req_valid = 1'b0; lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err} !== 68'h0) begin
      n_err++; $display("FAIL rst_rsp got %h/%b%b%b%b want 0", rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err); end
    n_vec++; if ({alu_a, alu_b, alu_cntl, alu_carry_in} !== 69'h0) begin
      n_err++; $display("FAIL rst_alu got %h %h %b %b want 0", alu_a, alu_b, alu_cntl, alu_carry_in); end
  endtask

  task automatic test_add_overflow;
    req_op = 4'd0; req_a = 64'h7FFFFFFF; req_b = 64'h1; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL add_busy got %b want 0", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_early got %b want 0", rsp_valid); end
    n_vec++; if ({alu_a, alu_b, alu_cntl, alu_carry_in} !== {32'h7FFFFFFF, 32'h1, 4'b0010, 1'b0}) begin
      n_err++; $display("FAIL add_drive got %h %h %b %b want 7fffffff 00000001 0010 0", alu_a, alu_b, alu_cntl, alu_carry_in); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_lat got %b want 1", rsp_valid); end
    n_vec++; if (rsp_result !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL add_res got %h want 0000000080000000", rsp_result); end
    n_vec++; if ({rsp_zero, rsp_carry, rsp_overflow, rsp_err} !== 4'b0010) begin
      n_err++; $display("FAIL add_flags got z%b c%b v%b e%b want z0 c0 v1 e0", rsp_zero, rsp_carry, rsp_overflow, rsp_err); end
    n_vec++; if ({alu_a, alu_b, alu_cntl, alu_carry_in} !== 69'h0) begin
      n_err++; $display("FAIL add_alu_idle got %h %h %b %b want 0", alu_a, alu_b, alu_cntl, alu_carry_in); end
    tick();
  endtask

  task automatic test_single_ops;
    int lat;
    // SUB with borrow: 5 - 7
    issue(4'd1, 64'h5, 64'h7, lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sub_lat got %0d want 2", lat); end
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow} !== {64'hFFFFFFFE, 3'b000}) begin
      n_err++; $display("FAIL sub_res got %h z%b c%b v%b want 00000000fffffffe z0 c0 v0", rsp_result, rsp_zero, rsp_carry, rsp_overflow); end
    tick();
    // AND to zero; carry must be a clean 0, not Z
    issue(4'd2, 64'hF0, 64'h0F, lat);
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err} !== {64'h0, 4'b1000}) begin
      n_err++; $display("FAIL and_res got %h z%b c%b v%b e%b want 0 z1 c0 v0 e0", rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err); end
    tick();
    // SLT signed: -1 < 1; upper operand bits ignored
    issue(4'd6, 64'hDEAD_0000_FFFF_FFFF, 64'h1, lat);
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry} !== {64'h1, 2'b00}) begin
      n_err++; $display("FAIL slt_res got %h z%b c%b want 0000000000000001 z0 c0", rsp_result, rsp_zero, rsp_carry); end
    tick();
    // NOR 0,0 -> all ones
    issue(4'd5, 64'h0, 64'h0, lat);
    n_vec++; if (rsp_result !== 64'hFFFFFFFF) begin n_err++; $display("FAIL nor_res got %h want 00000000ffffffff", rsp_result); end
    tick();
  endtask

  task automatic test_wide_sub;
`ifdef ALU_SEQ_WIDE_EN
    req_op = 4'd10; req_a = 64'h0000_0001_0000_0000; req_b = 64'h1; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    n_vec++; if ({alu_a, alu_b, alu_cntl, alu_carry_in} !== {32'h0, 32'hFFFFFFFE, 4'b0010, 1'b1}) begin
      n_err++; $display("FAIL sub64_lo got %h %h %b %b want 00000000 fffffffe 0010 1", alu_a, alu_b, alu_cntl, alu_carry_in); end
    tick();
    n_vec++; if ({alu_a, alu_b, alu_cntl, alu_carry_in, rsp_valid} !== {32'h1, 32'hFFFFFFFF, 4'b0010, 2'b00}) begin
      n_err++; $display("FAIL sub64_hi got %h %h %b cin%b v%b want 00000001 ffffffff 0010 cin0 v0", alu_a, alu_b, alu_cntl, alu_carry_in, rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sub64_lat got %b want 1", rsp_valid); end
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err} !== {64'h0000_0000_FFFF_FFFF, 4'b0100}) begin
      n_err++; $display("FAIL sub64_res got %h z%b c%b v%b e%b want 00000000ffffffff z0 c1 v0 e0", rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err); end
    tick();
`else
    int lat;
    issue(4'd10, 64'h0000_0001_0000_0000, 64'h1, lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sub64_lat got %0d want 2", lat); end
    n_vec++; if ({rsp_result, rsp_zero, rsp_err} !== {64'h0, 2'b11}) begin
      n_err++; $display("FAIL sub64_err got %h z%b e%b want 0 z1 e1", rsp_result, rsp_zero, rsp_err); end
    tick();
`endif
  endtask

  task automatic test_wide_add;
    int lat;
`ifdef ALU_SEQ_WIDE_EN
    issue(4'd9, 64'h0000_0000_FFFF_FFFF, 64'h1, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL add64_lat got %0d want 3", lat); end
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err} !== {64'h0000_0001_0000_0000, 4'b0000}) begin
      n_err++; $display("FAIL add64_res got %h z%b c%b v%b e%b want 0000000100000000 z0 c0 v0 e0", rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err); end
    tick();
    // Full wrap: both halves zero, carry out of the top word
    issue(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow} !== {64'h0, 3'b110}) begin
      n_err++; $display("FAIL add64_wrap got %h z%b c%b v%b want 0 z1 c1 v0", rsp_result, rsp_zero, rsp_carry, rsp_overflow); end
    tick();
`else
    issue(4'd9, 64'h1234_5678_FFFF_FFFF, 64'h1, lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add64_lat got %0d want 2", lat); end
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_err} !== {64'h0, 3'b101}) begin
      n_err++; $display("FAIL add64_err got %h z%b c%b e%b want 0 z1 c0 e1", rsp_result, rsp_zero, rsp_carry, rsp_err); end
    tick();
`endif
  endtask

  task automatic test_illegal;
    int lat;
    req_op = 4'hF; req_a = 64'h55; req_b = 64'hAA; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    n_vec++; if ({alu_a, alu_b, alu_cntl, alu_carry_in} !== 69'h0) begin
      n_err++; $display("FAIL ill_drive got %h %h %b %b want 0", alu_a, alu_b, alu_cntl, alu_carry_in); end
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL ill_lat got %0d want 2", lat); end
    n_vec++; if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err} !== {64'h0, 4'b1001}) begin
      n_err++; $display("FAIL ill_res got %h z%b c%b v%b e%b want 0 z1 c0 v0 e1", rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err); end
    tick();
  endtask

  task automatic test_backpressure;
    int lat;
    rsp_ready = 1'b0;
    issue(4'd8, 64'h3, 64'h3, lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL bne_lat got %0d want 2", lat); end
    // A competing request must not be taken while the response is pending
    req_op = 4'd0; req_a = 64'h5; req_b = 64'h6; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if ({rsp_valid, req_ready, rsp_result} !== {2'b10, 64'h11111111}) begin
        n_err++; $display("FAIL bp_hold[%0d] got v%b r%b %h want v1 r0 0000000011111111", i, rsp_valid, req_ready, rsp_result); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL bp_release got r%b v%b want r1 v0", req_ready, rsp_valid); end
    tick(); req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_accept got %b want 0", req_ready); end
    tick();
    n_vec++; if ({rsp_valid, rsp_result} !== {1'b1, 64'd11}) begin
      n_err++; $display("FAIL bp_next got v%b %h want v1 000000000000000b", rsp_valid, rsp_result); end
    tick();
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    req_op = 4'd3; req_a = 64'h1; req_b = 64'h2; req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (rsp_valid) begin
        pulses++;
        n_vec++; if (rsp_result !== 64'h3) begin n_err++; $display("FAIL b2b_res got %h want 3", rsp_result); end
      end
    end
    req_valid = 1'b0;
    n_vec++; if (pulses !== 3) begin n_err++; $display("FAIL b2b_rate got %0d want 3", pulses); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end got %b want 1", req_ready); end
  endtask

  task automatic test_reset_mid_op;
    int lat, seen;
`ifdef ALU_SEQ_WIDE_EN
    req_op = 4'd9; req_a = 64'h0000_0000_FFFF_FFFF; req_b = 64'h1; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    tick();
    n_vec++; if ({alu_a, alu_carry_in} !== {32'h0, 1'b1}) begin
      n_err++; $display("FAIL rmid_hi got %h cin%b want 00000000 cin1", alu_a, alu_carry_in); end
`else
    req_op = 4'd0; req_a = 64'h9; req_b = 64'h9; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
`endif
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL rmid_state got r%b v%b want r1 v0", req_ready, rsp_valid); end
    n_vec++; if ({alu_a, alu_b, alu_cntl, alu_carry_in} !== 69'h0) begin
      n_err++; $display("FAIL rmid_alu got %h %h %b %b want 0", alu_a, alu_b, alu_cntl, alu_carry_in); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (rsp_valid) seen++; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rmid_norsp got %0d want 0", seen); end
    issue(4'd0, 64'h2, 64'h2, lat);
    n_vec++; if ({rsp_valid, rsp_result, rsp_err} !== {1'b1, 64'h4, 1'b0}) begin
      n_err++; $display("FAIL rmid_after got v%b %h e%b want v1 0000000000000004 e0", rsp_valid, rsp_result, rsp_err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_single_ops();
    test_wide_sub();
    test_wide_add();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
